// File: rtl/image_writer_if.sv
// Pixel stream in, memory port A out, plus frame control/status for image_writer.
// The abort signal exists only when IMAGE_WRITER_ABORT_EN is defined.
interface image_writer_if;
   logic        start;
   logic [7:0]  pixel_in;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [15:0] address;
   logic [63:0] inputData;
   logic        writeEnable;
   logic        busy;
   logic        done;
`ifdef IMAGE_WRITER_ABORT_EN
   logic        abort;

   modport master (
      output start, pixel_in, pixel_valid, abort,
      input  pixel_ready, address, inputData, writeEnable, busy, done
   );
   modport slave (
      input  start, pixel_in, pixel_valid, abort,
      output pixel_ready, address, inputData, writeEnable, busy, done
   );
`else
   modport master (
      output start, pixel_in, pixel_valid,
      input  pixel_ready, address, inputData, writeEnable, busy, done
   );
   modport slave (
      input  start, pixel_in, pixel_valid,
      output pixel_ready, address, inputData, writeEnable, busy, done
   );
`endif
endinterface

// File: rtl/image_writer.sv
// Packs 8-bit pixels into 64-bit words and writes one frame to memory port A.
// Optional abort input enabled by defining IMAGE_WRITER_ABORT_EN.
module image_writer #(
   parameter int unsigned IMG_WIDTH  = 256,
   parameter int unsigned IMG_HEIGHT = 256,
   parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
   input logic            clk_FPGA,
   input logic            rst,
   image_writer_if.slave  bus
);

   localparam int unsigned Words    = IMG_WIDTH * IMG_HEIGHT / 8;
   localparam logic [16:0] LastWord = 17'(Words - 1);

   if ((IMG_WIDTH * IMG_HEIGHT) % 8 != 0) begin : gen_bad_size
      $error("image_writer: IMG_WIDTH*IMG_HEIGHT must be a multiple of 8");
   end

   typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [63:0] data_q, data_d;
   logic [2:0]  byte_q, byte_d;
   logic [16:0] word_q, word_d;
   logic        we_q, we_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        abort_req;

`ifdef IMAGE_WRITER_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      byte_d  = byte_q;
      word_d  = word_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               addr_d  = BASE_ADDR;
               byte_d  = 3'd0;
               word_d  = 17'd0;
               state_d = StFill;
            end
         end
         StFill: begin
            if (bus.pixel_valid) begin
               data_d[{byte_q, 3'b000} +: 8] = bus.pixel_in;
               byte_d = byte_q + 3'd1;
               if (byte_q == 3'd7) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            word_d = word_q + 17'd1;
            byte_d = 3'd0;
            // Address stays on the last written word once the frame is complete.
            if (word_q == LastWord) begin
               state_d = StDone;
            end else begin
               addr_d  = addr_q + 16'd1;
               state_d = StFill;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort_req && (state_q == StFill || state_q == StWrite)) begin
         state_d = StIdle;
      end

      // Strobes are registered from the next state so they align with it.
      we_d   = (state_d == StWrite);
      busy_d = (state_d == StFill) || (state_d == StWrite);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk_FPGA or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= 16'd0;
         data_q  <= 64'd0;
         byte_q  <= 3'd0;
         word_q  <= 17'd0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.pixel_ready = (state_q == StFill);
   assign bus.address     = addr_q;
   assign bus.inputData   = data_q;
   assign bus.writeEnable = we_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_image_writer.sv
// Directed bench for image_writer: a 4x4 frame at 0x0010 and a default-size frame.
// Abort steps are compiled only when IMAGE_WRITER_ABORT_EN is defined.
module tb_image_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   image_writer_if sif ();
   image_writer_if bif ();

   image_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .BASE_ADDR(16'h0010)) u_small (
      .clk_FPGA (clk),
      .rst      (rst),
      .bus      (sif.slave)
   );

   image_writer u_big (
      .clk_FPGA (clk),
      .rst      (rst),
      .bus      (bif.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Small-DUT write log and strobe counters.
   logic [15:0] wr_addr [16];
   logic [63:0] wr_data [16];
   int wr_n = 0;
   int rdy_bad = 0;
   int dn = 0;

   always @(negedge clk) begin
      if (sif.writeEnable) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] <= sif.address;
            wr_data[wr_n] <= sif.inputData;
         end
         wr_n <= wr_n + 1;
         if (sif.pixel_ready) rdy_bad <= rdy_bad + 1;
      end
      if (sif.done) dn <= dn + 1;
   end

   // Big-DUT write statistics.
   int b_writes = 0;
   int b_seq_err = 0;
   int b_dones = 0;
   logic [15:0] b_first = 16'hFFFF;
   logic [15:0] b_last = 16'hFFFF;

   always @(negedge clk) begin
      if (bif.writeEnable) begin
         if (b_writes == 0) b_first <= bif.address;
         else if (bif.address != b_last + 16'd1) b_seq_err <= b_seq_err + 1;
         b_last   <= bif.address;
         b_writes <= b_writes + 1;
      end
      if (bif.done) b_dones <= b_dones + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input bit bp, input bit poke, output int cyc);
      int idx;
      bit acc;
      bit got;
      idx = 0;
      acc = 1'b0;
      got = 1'b0;
      cyc = 0;
      @(negedge clk);
      sif.start = 1'b1;
      sif.pixel_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cyc++;
         if (acc) idx++;
         if (sif.done) begin
            got = 1'b1;
            break;
         end
         sif.start = poke && (i == 3 || sif.writeEnable);
         sif.pixel_valid = (idx < 16) && (!bp || $urandom_range(0, 2) != 0);
         sif.pixel_in = 8'(idx);
         acc = sif.pixel_valid && sif.pixel_ready;
      end
      sif.start = 1'b0;
      sif.pixel_valid = 1'b0;
      if (!got) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_frame(input int base_n, input int base_dn, input string tag);
      @(negedge clk);
      #1;
      check({tag, "_nwrites"}, 64'(wr_n - base_n), 64'd2);
      check({tag, "_addr0"}, 64'(wr_addr[base_n]), 64'h0010);
      check({tag, "_data0"}, wr_data[base_n], 64'h0706050403020100);
      check({tag, "_addr1"}, 64'(wr_addr[base_n + 1]), 64'h0011);
      check({tag, "_data1"}, wr_data[base_n + 1], 64'h0F0E0D0C0B0A0908);
      check({tag, "_ndone"}, 64'(dn - base_dn), 64'd1);
      check({tag, "_ready_in_write"}, 64'(rdy_bad), 64'd0);
      check({tag, "_done_pulse"}, 64'(sif.done), 64'd0);
      check({tag, "_busy_after"}, 64'(sif.busy), 64'd0);
      check({tag, "_addr_hold"}, 64'(sif.address), 64'h0011);
   endtask

   initial begin
      int cyc;
      int bn;
      int bd;
      bit got;

      sif.start = 1'b0;
      sif.pixel_in = 8'd0;
      sif.pixel_valid = 1'b0;
      bif.start = 1'b0;
      bif.pixel_in = 8'hA5;
      bif.pixel_valid = 1'b0;
`ifdef IMAGE_WRITER_ABORT_EN
      sif.abort = 1'b0;
      bif.abort = 1'b0;
`endif

      // Reset values.
      #12;
      check("rst_ready", 64'(sif.pixel_ready), 64'd0);
      check("rst_addr", 64'(sif.address), 64'd0);
      check("rst_data", sif.inputData, 64'd0);
      check("rst_we", 64'(sif.writeEnable), 64'd0);
      check("rst_busy", 64'(sif.busy), 64'd0);
      check("rst_done", 64'(sif.done), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Continuous stream: 19 cycles from start to done.
      bn = wr_n;
      bd = dn;
      run_frame(1'b0, 1'b0, cyc);
      check("plain_cycles", 64'(cyc), 64'd19);
      check_frame(bn, bd, "plain");

      // Random backpressure.
      bn = wr_n;
      bd = dn;
      run_frame(1'b1, 1'b0, cyc);
      check_frame(bn, bd, "bp");

      // start pulses during FILL and WRITE are ignored.
      bn = wr_n;
      bd = dn;
      run_frame(1'b0, 1'b1, cyc);
      check("poke_cycles", 64'(cyc), 64'd19);
      check_frame(bn, bd, "poke");

      // Asynchronous reset after 5 pixels.
      bn = wr_n;
      @(negedge clk);
      sif.start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         sif.start = 1'b0;
         sif.pixel_valid = 1'b1;
         sif.pixel_in = 8'(k);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", 64'(sif.pixel_ready), 64'd0);
      check("arst_addr", 64'(sif.address), 64'd0);
      check("arst_data", sif.inputData, 64'd0);
      check("arst_we", 64'(sif.writeEnable), 64'd0);
      check("arst_busy", 64'(sif.busy), 64'd0);
      check("arst_done", 64'(sif.done), 64'd0);
      sif.pixel_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_nowrite", 64'(wr_n - bn), 64'd0);
      bn = wr_n;
      bd = dn;
      run_frame(1'b0, 1'b0, cyc);
      check_frame(bn, bd, "after_rst");

`ifdef IMAGE_WRITER_ABORT_EN
      // Abort in the cycle the 8th pixel is accepted.
      bn = wr_n;
      bd = dn;
      @(negedge clk);
      sif.start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         sif.start = 1'b0;
         sif.pixel_valid = 1'b1;
         sif.pixel_in = 8'(k);
         sif.abort = (k == 7);
      end
      @(negedge clk);
      sif.abort = 1'b0;
      sif.pixel_valid = 1'b0;
      check("abort_we", 64'(sif.writeEnable), 64'd0);
      check("abort_ready", 64'(sif.pixel_ready), 64'd0);
      check("abort_busy", 64'(sif.busy), 64'd0);
      check("abort_done", 64'(sif.done), 64'd0);
      repeat (3) @(negedge clk);
      #1;
      check("abort_nowrite", 64'(wr_n - bn), 64'd0);
      check("abort_nodone", 64'(dn - bd), 64'd0);
`endif

      // Default-size frame with a continuous stream.
      got = 1'b0;
      @(negedge clk);
      bif.start = 1'b1;
      bif.pixel_valid = 1'b1;
      for (int i = 0; i < 80000; i++) begin
         @(negedge clk);
         bif.start = 1'b0;
         if (bif.done) begin
            got = 1'b1;
            break;
         end
      end
      bif.pixel_valid = 1'b0;
      if (!got) check("big_done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      #1;
      check("big_nwrites", 64'(b_writes), 64'd8192);
      check("big_first", 64'(b_first), 64'h0000);
      check("big_last", 64'(b_last), 64'h1FFF);
      check("big_seq", 64'(b_seq_err), 64'd0);
      check("big_ndone", 64'(b_dones), 64'd1);
      check("big_addr_hold", 64'(bif.address), 64'h1FFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
